// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU memory stage and the FFT accelerator.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    ACC  = 2'd2
  } owner_e;

  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_BURST_MAX = 8;
  localparam int unsigned DEF_AGE_LIMIT = 4;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_age_ctr.sv
// Saturating age counter: counts CPU-won cycles while ACC waits; clear has priority over increment.
module dmem_arb_age_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_AGE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int unsigned W = cnt_width(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority, locked ACC bursts, read data returned to its owner.
// Define DMEM_ARB_AGING_EN to force ACC through after AGE_LIMIT cycles lost to the CPU.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_MAX = DEF_BURST_MAX,
  parameter int unsigned AGE_LIMIT = DEF_AGE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  input  logic              acc_last,
  output logic              acc_gnt,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_e        dbg_state_o
);

  // Handshake: a request is held until granted; a grant is a same-cycle combinational
  // accept of that beat, and load data comes back exactly one cycle after its grant.

  localparam int unsigned BW = cnt_width(BURST_MAX);

  arb_state_e   state_q, state_d;
  logic [BW-1:0] beat_q, beat_d, beat_inc;
  owner_e       rd_owner_q, rd_owner_d;
  logic         cpu_gnt;
  logic         force_acc;

`ifdef DMEM_ARB_AGING_EN
  logic age_at_limit;

  dmem_arb_age_ctr #(.LIMIT(AGE_LIMIT)) u_age_ctr (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (acc_gnt),
    .inc_i      (cpu_gnt && acc_req),
    .at_limit_o (age_at_limit)
  );

  assign force_acc = age_at_limit && acc_req;
`else
  // AGE_LIMIT has no effect without aging; tied off so strict CPU priority holds.
  assign force_acc = 1'b0 & (AGE_LIMIT > 0);
`endif

  assign beat_inc = beat_q + 1'b1;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cpu_gnt = 1'b0;
    acc_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (cpu_req && !force_acc) begin
            cpu_gnt = 1'b1;
          end else if (acc_req) begin
            acc_gnt = 1'b1;
            if (!acc_last && (BURST_MAX > 1)) begin
              state_d = LOCK;
              beat_d  = BW'(1);
            end
          end
        end
        LOCK: begin
          // Dropping acc_req mid-burst releases the lock without a grant.
          if (acc_req) begin
            acc_gnt = 1'b1;
            beat_d  = beat_inc;
            if (acc_last || (beat_inc == BW'(BURST_MAX))) begin
              state_d = IDLE;
              beat_d  = '0;
            end
          end else begin
            state_d = IDLE;
            beat_d  = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_owner_d = NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = CPU;
    end else if (acc_gnt && !acc_we) begin
      rd_owner_d = ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      rd_owner_q <= NONE;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (acc_gnt) begin
      mem_we    = acc_we;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
    end
  end

  assign cpu_stall   = cpu_req & ~cpu_gnt;
  assign cpu_rvalid  = (rd_owner_q == CPU) & ~reset;
  assign acc_rvalid  = (rd_owner_q == ACC) & ~reset;
  assign cpu_rdata   = cpu_rvalid ? mem_rdata : '0;
  assign acc_rdata   = acc_rvalid ? mem_rdata : '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int BMAX = 8;
  localparam int ALIM = 4;
`ifdef DMEM_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          acc_req, acc_we, acc_last, acc_gnt, acc_rvalid;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata, acc_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  arb_state_e    dbg_state;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX), .AGE_LIMIT(ALIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_last(acc_last), .acc_gnt(acc_gnt), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // data memory with registered read
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: reference memory, pending read returns, burst/age bookkeeping
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q[$];
  int            own_q[$];
  bit            m_locked = 1'b0;
  int            m_beats  = 0;
  int            m_age    = 0;

  always @(negedge clk) begin : model
    bit            cg, ag;
    int            po;
    logic [DW-1:0] pd;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    po = 0; pd = '0; cg = 1'b0; ag = 1'b0;
    if (own_q.size() > 0) begin
      po = own_q.pop_front();
      pd = exp_q.pop_front();
    end
    if (reset) begin
      po = 0;
    end else if (m_locked) begin
      ag = acc_req;
    end else begin
      cg = cpu_req && !(AGING && (m_age >= ALIM) && acc_req);
      ag = acc_req && !cg;
    end
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (cg) begin
      e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
    end else if (ag) begin
      e_we = acc_we; e_addr = acc_addr; e_wdata = acc_wdata;
    end
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req & ~cg});
    chk("acc_gnt", {31'b0, acc_gnt}, {31'b0, ag});
    chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, po == 1});
    chk("acc_rvalid", {31'b0, acc_rvalid}, {31'b0, po == 2});
    if (po == 1) chk("cpu_rdata", cpu_rdata, pd);
    if (po == 2) chk("acc_rdata", acc_rdata, pd);

    if (reset) begin
      m_locked = 1'b0; m_beats = 0; m_age = 0;
    end else begin
      if (ag) begin
        m_beats  = m_locked ? m_beats + 1 : 1;
        m_locked = !(acc_last || (m_beats == BMAX));
        if (!m_locked) m_beats = 0;
        m_age = 0;
      end else if (m_locked) begin
        m_locked = 1'b0; m_beats = 0;
      end else if (cg && acc_req && (m_age < ALIM)) begin
        m_age++;
      end
      if (cg && !cpu_we) begin own_q.push_back(1); exp_q.push_back(ref_mem[cpu_addr]); end
      if (ag && !acc_we) begin own_q.push_back(2); exp_q.push_back(ref_mem[acc_addr]); end
      if (cg && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (ag && acc_we) ref_mem[acc_addr] = acc_wdata;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0; acc_last = 1'b0;
  endtask

  initial begin
    int stalls, gnts, first;
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'hDEAD_BEEF;
    ref_mem[3] = 32'hDEAD_BEEF;

    // reset with both requesters active
    cpu_req = 1'b1; acc_req = 1'b1;
    @(negedge clk);
    chk("rst_acc_gnt", {31'b0, acc_gnt}, 32'd0);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    tick();

    // 1: CPU load from address 3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
    @(negedge clk);
    chk("t1_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t1_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // 2: four-beat ACC burst, CPU arrives at beat 2
    stalls = 0;
    for (int b = 1; b <= 4; b++) begin
      acc_req = 1'b1; acc_we = 1'b1; acc_addr = 4'(8 + b); acc_wdata = $urandom;
      acc_last = (b == 4);
      cpu_req = (b >= 2); cpu_we = 1'b0; cpu_addr = 4'd1;
      @(negedge clk);
      if (cpu_stall) stalls++;
      tick();
    end
    acc_req = 1'b0; acc_last = 1'b0;
    @(negedge clk);
    chk("t2_cpu_win", {31'b0, cpu_stall}, 32'd0);
    chk("t2_stalls", 32'(stalls), 32'd3);
    tick();
    idle_inputs();
    tick();

    // 3: burst with no acc_last is cut at BURST_MAX
    gnts = 0;
    for (int c = 1; c <= 9; c++) begin
      acc_req = 1'b1; acc_we = 1'b0; acc_addr = 4'(c); acc_last = 1'b0;
      cpu_req = (c >= 2); cpu_we = 1'b0; cpu_addr = 4'd2;
      @(negedge clk);
      if (acc_gnt) gnts++;
      if (c == 9) begin
        chk("t3_cpu_after", {31'b0, cpu_stall}, 32'd0);
        chk("t3_acc_gnt_c9", {31'b0, acc_gnt}, 32'd0);
      end
      tick();
    end
    chk("t3_beats", 32'(gnts), 32'd8);
    idle_inputs();
    tick();

    // 5: reset at beat 3 of a locked load burst
    for (int c = 1; c <= 3; c++) begin
      acc_req = 1'b1; acc_we = 1'b0; acc_addr = 4'(c); acc_last = 1'b0;
      reset = (c == 3);
      @(negedge clk);
      if (c == 3) begin
        chk("t5_rst_gnt", {31'b0, acc_gnt}, 32'd0);
        chk("t5_rst_rvalid", {31'b0, acc_rvalid}, 32'd0);
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("t5_state", 32'(dbg_state), 32'(IDLE));
    chk("t5_rvalid_after", {31'b0, acc_rvalid | cpu_rvalid}, 32'd0);
    tick();
    acc_req = 1'b1; acc_last = 1'b1;
    @(negedge clk);
    chk("t5_new_gnt", {31'b0, acc_gnt}, 32'd1);
    tick();
    idle_inputs();
    tick();

    // 4: both requesting for 10 cycles
    stalls = 0; gnts = 0; first = 0;
    for (int c = 1; c <= 10; c++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'($urandom_range(0, 15));
      acc_req = 1'b1; acc_we = 1'b0; acc_addr = 4'($urandom_range(0, 15)); acc_last = 1'b1;
      @(negedge clk);
      if (acc_gnt) begin
        gnts++;
        if (first == 0) first = c;
      end
      if (cpu_stall) stalls++;
      tick();
    end
`ifdef DMEM_ARB_AGING_EN
    chk("t4_first_acc", 32'(first), 32'd5);
    chk("t4_stalls", 32'(stalls), 32'd2);
`else
    chk("t4_acc_gnts", 32'(gnts), 32'd0);
    chk("t4_stalls", 32'(stalls), 32'd0);
`endif
    idle_inputs();
    tick();

    // 6: CPU store then ACC load, same address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 32'h5;
    @(negedge clk);
    chk("t6_store", {31'b0, cpu_stall}, 32'd0);
    tick();
    idle_inputs();
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 4'd7; acc_last = 1'b1;
    @(negedge clk);
    chk("t6_acc_gnt", {31'b0, acc_gnt}, 32'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t6_rvalid", {31'b0, acc_rvalid}, 32'd1);
    chk("t6_rdata", acc_rdata, 32'h5);
    tick();

    // random traffic; a stalled CPU request is held unchanged
    for (int n = 0; n < 3000; n++) begin
      bit granted;
      @(negedge clk);
      granted = cpu_req && !cpu_stall && !reset;
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if (!cpu_req || granted) begin
        cpu_req = ($urandom_range(0, 99) < 50);
        cpu_we = $urandom_range(0, 1);
        cpu_addr = 4'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      acc_req = ($urandom_range(0, 99) < 60);
      acc_we = $urandom_range(0, 1);
      acc_addr = 4'($urandom_range(0, 15));
      acc_wdata = $urandom;
      acc_last = ($urandom_range(0, 3) == 0);
    end
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
